// File: rtl/fractal_frame_sequencer_if.sv
// Control/parameter bundle between host register file, sequencer and the monitored video stream.
// Purely wires; no storage.
// Handshake signals are observed only; the sequencer never drives tready.
interface fractal_frame_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              enable;
    logic              animate;
    logic              commit;
    logic [DATA_W-1:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_cr, cfg_ci;
    logic [DATA_W-1:0] cfg_dcr, cfg_dci;
    logic              s_tvalid, s_tready, s_tuser, s_tlast;
    logic              gen_resetn;
    logic [DATA_W-1:0] gen_x0, gen_y0, gen_dx, gen_dy, gen_cr, gen_ci;
    logic [31:0]       frame_count;
    logic              commit_pending;
    logic              running;

    // Host / environment side: drives configuration and the stream handshake.
    modport master (
        output enable, animate, commit,
        output cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_cr, cfg_ci, cfg_dcr, cfg_dci,
        output s_tvalid, s_tready, s_tuser, s_tlast,
        input  gen_resetn, gen_x0, gen_y0, gen_dx, gen_dy, gen_cr, gen_ci,
        input  frame_count, commit_pending, running
    );

    // Sequencer side.
    modport slave (
        input  enable, animate, commit,
        input  cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_cr, cfg_ci, cfg_dcr, cfg_dci,
        input  s_tvalid, s_tready, s_tuser, s_tlast,
        output gen_resetn, gen_x0, gen_y0, gen_dx, gen_dy, gen_cr, gen_ci,
        output frame_count, commit_pending, running
    );
endinterface

// File: rtl/fractal_frame_sequencer.sv
// Frame sequencer: holds the generator in reset, releases it, applies parameters only at frame ends.
// Latency: all outputs registered; parameter changes visible the cycle after the triggering edge.
// Backpressure: none exerted; the stream is only monitored, beats count on tvalid & tready.
module fractal_frame_sequencer #(
    parameter int HEIGHT       = 1080,
    parameter int RESET_CYCLES = 4,
    parameter int DATA_W       = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    fractal_frame_sequencer_if.slave   bus
);
    localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
    localparam logic [RW-1:0] LAST_RST  = RW'(RESET_CYCLES - 1);
    localparam bit ONE_LINE = (HEIGHT == 1);

    typedef struct packed {
        logic [DATA_W-1:0] x0;
        logic [DATA_W-1:0] y0;
        logic [DATA_W-1:0] dx;
        logic [DATA_W-1:0] dy;
        logic [DATA_W-1:0] cr;
        logic [DATA_W-1:0] ci;
    } params_t;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t        state;
    params_t       cfg, stg, act;
    logic [LW-1:0] line_cnt;
    logic [RW-1:0] rst_cnt;
    logic [31:0]   frame_count;
    logic          pending;
    logic          gen_resetn;
    logic          running;

    logic beat, line_end, sof, frame_end;

    assign cfg = '{x0: bus.cfg_x0, y0: bus.cfg_y0, dx: bus.cfg_dx,
                   dy: bus.cfg_dy, cr: bus.cfg_cr, ci: bus.cfg_ci};

    // Stream event decode; a sof that is also tlast only closes a frame when a frame is one line tall.
    always_comb begin
        beat      = bus.s_tvalid & bus.s_tready;
        line_end  = beat & bus.s_tlast;
        sof       = beat & bus.s_tuser;
        frame_end = 1'b0;
        if (line_end) begin
            if (sof) frame_end = ONE_LINE;
            else     frame_end = (line_cnt == LAST_LINE);
        end
    end

    // Sequencer FSM with registered outputs, line/frame tracking and parameter staging.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            gen_resetn  <= 1'b0;
            running     <= 1'b0;
            act         <= '0;
            stg         <= '0;
            frame_count <= '0;
            pending     <= 1'b0;
            line_cnt    <= '0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gen_resetn <= 1'b0;
                    running    <= 1'b0;
                    if (bus.enable) begin
                        state   <= START;
                        act     <= cfg;
                        pending <= 1'b0;
                        rst_cnt <= '0;
                    end
                end
                START: begin
                    if (!bus.enable) begin
                        state    <= IDLE;
                        line_cnt <= '0;
                    end else if (rst_cnt == LAST_RST) begin
                        state      <= RUN;
                        gen_resetn <= 1'b1;
                        running    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state      <= IDLE;
                        gen_resetn <= 1'b0;
                        running    <= 1'b0;
                        line_cnt   <= '0;
                    end else if (frame_end) begin
                        line_cnt    <= '0;
                        frame_count <= frame_count + 32'd1;
                        if (pending) begin
                            act     <= stg;
                            pending <= 1'b0;
                        end else if (bus.animate) begin
                            act.cr <= act.cr + bus.cfg_dcr;
                            act.ci <= act.ci + bus.cfg_dci;
                        end
                    end else if (sof) begin
                        line_cnt <= line_end ? LW'(1) : '0;
                    end else if (line_end) begin
                        line_cnt <= line_cnt + LW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    gen_resetn <= 1'b0;
                    running    <= 1'b0;
                end
            endcase
            // A commit always wins over the pending-clear above, so new values wait for the next boundary.
            if (bus.commit) begin
                stg     <= cfg;
                pending <= 1'b1;
            end
        end
    end

    assign bus.gen_resetn     = gen_resetn;
    assign bus.running        = running;
    assign bus.gen_x0         = act.x0;
    assign bus.gen_y0         = act.y0;
    assign bus.gen_dx         = act.dx;
    assign bus.gen_dy         = act.dy;
    assign bus.gen_cr         = act.cr;
    assign bus.gen_ci         = act.ci;
    assign bus.frame_count    = frame_count;
    assign bus.commit_pending = pending;
endmodule

// File: tb/tb_fractal_frame_sequencer.sv
// Directed bench for fractal_frame_sequencer with HEIGHT=4, RESET_CYCLES=4.
// Inputs change and outputs are sampled 1ns after the rising edge.
// Expected values are hand-computed constants.
module tb_fractal_frame_sequencer;
    localparam int DATA_W = 32;

    logic aclk = 1'b0;
    logic aresetn;
    int   checks = 0;
    int   failures = 0;

    fractal_frame_sequencer_if #(.DATA_W(DATA_W)) bus ();

    fractal_frame_sequencer #(
        .HEIGHT(4), .RESET_CYCLES(4), .DATA_W(DATA_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic last, input logic user);
        bus.s_tvalid = 1'b1;
        bus.s_tready = 1'b1;
        bus.s_tlast  = last;
        bus.s_tuser  = user;
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tready = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = 1'b0;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) beat(1'b1, 1'b0);
    endtask

    task automatic set_c(input logic [31:0] cr, input logic [31:0] ci);
        bus.cfg_cr = cr;
        bus.cfg_ci = ci;
    endtask

    initial begin
        aresetn = 1'b0;
        bus.enable = 0; bus.animate = 0; bus.commit = 0;
        bus.cfg_x0 = 32'h0000_1000; bus.cfg_y0 = 32'h0000_2000;
        bus.cfg_dx = 32'h0000_0010; bus.cfg_dy = 32'h0000_0020;
        set_c(32'h0000_0011, 32'h0000_0022);
        bus.cfg_dcr = 0; bus.cfg_dci = 0;
        bus.s_tvalid = 0; bus.s_tready = 0; bus.s_tlast = 0; bus.s_tuser = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_gen_resetn", 32'(bus.gen_resetn), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_frame_count", bus.frame_count, 0);
        chk("rst_pending", 32'(bus.commit_pending), 0);
        chk("rst_gen_cr", bus.gen_cr, 0);
        aresetn = 1'b1;
        repeat (6) tick();

        // Enable: exactly 4 cycles of gen_resetn low after leaving IDLE
        bus.enable = 1'b1;
        tick();
        chk("start_gen_resetn", 32'(bus.gen_resetn), 0);
        chk("start_gen_cr", bus.gen_cr, 32'h0000_0011);
        chk("start_gen_x0", bus.gen_x0, 32'h0000_1000);
        repeat (3) tick();
        chk("start_last_low", 32'(bus.gen_resetn), 0);
        chk("start_running_low", 32'(bus.running), 0);
        tick();
        chk("run_gen_resetn", 32'(bus.gen_resetn), 1);
        chk("run_running", 32'(bus.running), 1);

        // Commit mid-frame, applied at the 4th tlast
        lines(2);
        set_c(32'h0001_0000, 32'h0000_0033);
        bus.cfg_x0 = 32'h0000_5000;
        bus.commit = 1'b1; tick(); bus.commit = 1'b0;
        chk("commit_pending", 32'(bus.commit_pending), 1);
        chk("commit_not_yet", bus.gen_cr, 32'h0000_0011);
        lines(1);
        chk("commit_pending_l3", 32'(bus.commit_pending), 1);
        chk("fc_before_end", bus.frame_count, 0);
        lines(1);
        chk("frame1_gen_cr", bus.gen_cr, 32'h0001_0000);
        chk("frame1_gen_x0", bus.gen_x0, 32'h0000_5000);
        chk("frame1_pending", 32'(bus.commit_pending), 0);
        chk("frame1_count", bus.frame_count, 1);

        // tlast without tready is not a beat
        bus.s_tvalid = 1; bus.s_tready = 0; bus.s_tlast = 1;
        tick();
        bus.s_tvalid = 0; bus.s_tlast = 0;
        lines(3);
        chk("stall_no_count", bus.frame_count, 1);
        lines(1);
        chk("stall_frame2", bus.frame_count, 2);

        // Commit applied with animate on: animate suppressed on that boundary
        bus.animate = 1'b1;
        bus.cfg_dcr = 32'h0000_0100; bus.cfg_dci = 32'hFFFF_FFFF;
        set_c(32'h7FFF_FF80, 32'h0000_0005);
        bus.commit = 1'b1; tick(); bus.commit = 1'b0;
        lines(4);
        chk("anim_commit_cr", bus.gen_cr, 32'h7FFF_FF80);
        chk("anim_commit_ci", bus.gen_ci, 32'h0000_0005);
        chk("anim_commit_fc", bus.frame_count, 3);
        // Animate frame: wraps past the positive limit
        lines(4);
        chk("anim_wrap_cr", bus.gen_cr, 32'h8000_0080);
        chk("anim_ci", bus.gen_ci, 32'h0000_0004);
        chk("anim_fc", bus.frame_count, 4);

        // Commit A mid-frame, commit B on the frame-end beat
        lines(2);
        set_c(32'h0000_000A, 32'h0000_00A1);
        bus.commit = 1'b1; tick(); bus.commit = 1'b0;
        lines(1);
        set_c(32'h0000_000B, 32'h0000_00B1);
        bus.commit = 1'b1; beat(1'b1, 1'b0); bus.commit = 1'b0;
        chk("ab_first_cr", bus.gen_cr, 32'h0000_000A);
        chk("ab_first_ci", bus.gen_ci, 32'h0000_00A1);
        chk("ab_pending", 32'(bus.commit_pending), 1);
        chk("ab_fc", bus.frame_count, 5);
        lines(4);
        chk("ab_second_cr", bus.gen_cr, 32'h0000_000B);
        chk("ab_second_pending", 32'(bus.commit_pending), 0);
        lines(4);
        chk("ab_anim_cr", bus.gen_cr, 32'h0000_010B);
        chk("ab_anim_ci", bus.gen_ci, 32'h0000_00B0);

        // Commit on the frame-end beat with nothing pending: animate applies, commit waits
        lines(3);
        set_c(32'h0000_000C, 32'h0000_00C1);
        bus.commit = 1'b1; beat(1'b1, 1'b0); bus.commit = 1'b0;
        chk("late_commit_cr", bus.gen_cr, 32'h0000_020B);
        chk("late_commit_pending", 32'(bus.commit_pending), 1);
        chk("late_commit_fc", bus.frame_count, 8);
        bus.animate = 1'b0;
        lines(4);
        chk("late_applied_cr", bus.gen_cr, 32'h0000_000C);
        chk("late_applied_fc", bus.frame_count, 9);

        // sof resync at line 2, then a full frame of tlasts
        lines(2);
        beat(1'b0, 1'b1);
        lines(3);
        chk("sof_resync_hold", bus.frame_count, 9);
        lines(1);
        chk("sof_resync_end", bus.frame_count, 10);
        // sof on a tlast beat counts as line 0 complete
        beat(1'b1, 1'b1);
        lines(2);
        chk("sof_last_hold", bus.frame_count, 10);
        lines(1);
        chk("sof_last_end", bus.frame_count, 11);

        // Drop enable mid-frame; beats while idle are ignored
        lines(2);
        bus.enable = 1'b0;
        tick();
        chk("drop_gen_resetn", 32'(bus.gen_resetn), 0);
        chk("drop_running", 32'(bus.running), 0);
        chk("drop_fc", bus.frame_count, 11);
        chk("drop_gen_cr", bus.gen_cr, 32'h0000_000C);
        lines(4);
        chk("idle_beats_ignored", bus.frame_count, 11);

        // Re-enable: full reset interval again, parameters loaded directly, line count restarted
        set_c(32'h0000_000D, 32'h0000_00D1);
        bus.enable = 1'b1;
        tick();
        chk("reen_gen_cr", bus.gen_cr, 32'h0000_000D);
        repeat (3) tick();
        chk("reen_low", 32'(bus.gen_resetn), 0);
        tick();
        chk("reen_high", 32'(bus.gen_resetn), 1);
        lines(3);
        chk("reen_line_hold", bus.frame_count, 11);
        lines(1);
        chk("reen_frame_end", bus.frame_count, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
